// File: rtl/module_display_scan_pkg.sv
// Shared types and constants for the four-digit display scanner.
package display_pkg;

  typedef enum logic [1:0] {
    SCAN_U = 2'd0,
    SCAN_D = 2'd1,
    SCAN_C = 2'd2,
    SCAN_M = 2'd3
  } scan_state_t;

  localparam logic [3:0] SEL_U = 4'b0001;
  localparam logic [3:0] SEL_D = 4'b0010;
  localparam logic [3:0] SEL_C = 4'b0100;
  localparam logic [3:0] SEL_M = 4'b1000;

  localparam int TICK_DIV_DEFAULT = 27000;

  // One-hot digit select for a scan state.
  function automatic logic [3:0] sel_code(input scan_state_t s);
    logic [3:0] code;
    code = SEL_U;
    case (s)
      SCAN_U:  code = SEL_U;
      SCAN_D:  code = SEL_D;
      SCAN_C:  code = SEL_C;
      SCAN_M:  code = SEL_M;
      default: code = SEL_U;
    endcase
    return code;
  endfunction

  // True when every nibble is a legal decimal digit.
  function automatic logic bcd_valid(input logic [15:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) &&
           (v[11:8] <= 4'd9) && (v[15:12] <= 4'd9);
  endfunction

  // Leading-zero test: the slot is dark when its digit and all more
  // significant digits are zero. Units always stays lit.
  function automatic logic blank_slot(input scan_state_t s, input logic [15:0] d);
    logic b;
    b = 1'b0;
    case (s)
      SCAN_M:  b = (d[15:12] == 4'd0);
      SCAN_C:  b = (d[15:8]  == 8'd0);
      SCAN_D:  b = (d[15:4]  == 12'd0);
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/module_display_scan_tick_gen.sv
// Prescaler: counts 0..DIV-1 and flags the last count as the scan tick.
module module_tick_gen #(
  parameter int DIV = display_pkg::TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // Free-running wrap counter, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick_o = (cnt == LAST);

endmodule

// File: rtl/module_display_scan.sv
// Four-digit multiplexed display scanner with validated BCD capture.
// Optional build macro: LEADING_ZERO_BLANK_EN (dark leading-zero slots).
//
// state  | meaning
// SCAN_U | units digit selected
// SCAN_D | tens digit selected
// SCAN_C | hundreds digit selected
// SCAN_M | thousands digit selected
module module_display_scan #(
  parameter int TICK_DIV = display_pkg::TICK_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd_i,
  input  logic        load_i,
  output logic [3:0]  unidades,
  output logic [3:0]  decenas,
  output logic [3:0]  centenas,
  output logic [3:0]  millares,
  output logic [3:0]  sel,
  output logic        err_o
);

  import display_pkg::*;

  logic        tick;
  scan_state_t state_q, state_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  sel_q, sel_d;
  logic        err_q, err_d;
  logic        bcd_ok;

  module_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  // State, digit, select and error registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= SCAN_U;
      digits_q <= 16'h0000;
      sel_q    <= SEL_U;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      sel_q    <= sel_d;
      err_q    <= err_d;
    end
  end

  // Next state, capture and select; sel follows the post-edge state and
  // digits so a load and a tick in the same cycle land together.
  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        SCAN_U:  state_d = SCAN_D;
        SCAN_D:  state_d = SCAN_C;
        SCAN_C:  state_d = SCAN_M;
        SCAN_M:  state_d = SCAN_U;
        default: state_d = SCAN_U;
      endcase
    end

    bcd_ok   = bcd_valid(bcd_i);
    digits_d = digits_q;
    if (load_i && bcd_ok) begin
      digits_d = bcd_i;
    end
    err_d = load_i && !bcd_ok;

    sel_d = sel_code(state_d);
`ifdef LEADING_ZERO_BLANK_EN
    if (blank_slot(state_d, digits_d)) begin
      sel_d = 4'b0000;
    end
`endif
  end

  assign unidades = digits_q[3:0];
  assign decenas  = digits_q[7:4];
  assign centenas = digits_q[11:8];
  assign millares = digits_q[15:12];
  assign sel      = sel_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_module_display_scan.sv
// Scoreboard bench for module_display_scan with TICK_DIV = 4.
module tb_module_display_scan;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bcd_i = 16'h0000;
  logic        load_i = 1'b0;
  logic [3:0]  unidades, decenas, centenas, millares, sel;
  logic        err_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0]  sel;
    logic [15:0] dig;
    logic        err;
  } exp_t;

  exp_t sb[$];

  // reference model state
  int          m_cnt  = 0;
  int          m_slot = 0;
  logic [15:0] m_dig  = 16'h0000;
  logic        m_err  = 1'b0;

  module_display_scan #(.TICK_DIV(DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bcd_i    (bcd_i),
    .load_i   (load_i),
    .unidades (unidades),
    .decenas  (decenas),
    .centenas (centenas),
    .millares (millares),
    .sel      (sel),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_sel(input int slot, input logic [15:0] d);
    logic [3:0] s;
    s = 4'b0001 << slot;
`ifdef LEADING_ZERO_BLANK_EN
    if (slot > 0 && (d >> (4 * slot)) == 16'h0000) s = 4'b0000;
`endif
    return s;
  endfunction

  function automatic logic bcd_bad(input logic [15:0] b);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) if (b[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  // One clock: drive inputs, predict post-edge outputs, compare after edge.
  task automatic step(input logic r, input logic ld, input logic [15:0] b);
    exp_t e;
    rst_n  = r;
    load_i = ld;
    bcd_i  = b;
    if (!r) begin
      m_cnt = 0; m_slot = 0; m_dig = 16'h0000; m_err = 1'b0;
    end else begin
      if (m_cnt == DIV - 1) begin
        m_cnt  = 0;
        m_slot = (m_slot + 1) % 4;
      end else begin
        m_cnt++;
      end
      m_err = ld && bcd_bad(b);
      if (ld && !bcd_bad(b)) m_dig = b;
    end
    e.sel = model_sel(m_slot, m_dig);
    e.dig = m_dig;
    e.err = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("sel", {28'd0, sel}, {28'd0, e.sel});
    chk("digits", {16'd0, millares, centenas, decenas, unidades}, {16'd0, e.dig});
    chk("err_o", {31'd0, err_o}, {31'd0, e.err});
    chk("onehot", {31'd0, ($countones(sel) <= 1)}, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0000);
  endtask

  initial begin
    int cnt_u, cnt_z, prev_slot, guard;
    logic [15:0] rb;

    // reset and free run
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    chk("reset_sel", {28'd0, sel}, 32'h1);
    chk("reset_err", {31'd0, err_o}, 32'd0);
    idle(16);

    // accepted load
    step(1'b1, 1'b1, 16'h1234);
    chk("load_1234", {16'd0, millares, centenas, decenas, unidades}, 32'h1234);
    idle(2);

    // rejected load keeps digits, one-cycle error
    step(1'b1, 1'b1, 16'h12A4);
    chk("reject_err", {31'd0, err_o}, 32'd1);
    chk("reject_keep", {16'd0, millares, centenas, decenas, unidades}, 32'h1234);
    idle(1);
    chk("reject_err_drop", {31'd0, err_o}, 32'd0);
    idle(2);

    // load coincident with tick
    guard = 0;
    while (m_cnt != DIV - 1 && guard < 2 * DIV) begin idle(1); guard++; end
    prev_slot = m_slot;
    step(1'b1, 1'b1, 16'h5678);
    chk("tick_load_dig", {16'd0, millares, centenas, decenas, unidades}, 32'h5678);
    chk("tick_load_sel", {28'd0, sel}, {28'd0, 4'b0001 << ((prev_slot + 1) % 4)});
    idle(3);

    // leading-zero patterns
    step(1'b1, 1'b1, 16'h0045);
    cnt_z = 0;
    for (int i = 0; i < 16; i++) begin idle(1); if (sel == 4'b0000) cnt_z++; end
`ifdef LEADING_ZERO_BLANK_EN
    chk("blank_0045", cnt_z, 8);
`else
    chk("blank_0045", cnt_z, 0);
`endif
    step(1'b1, 1'b1, 16'h0000);
    cnt_u = 0; cnt_z = 0;
    for (int i = 0; i < 16; i++) begin
      idle(1);
      if (sel == 4'b0001) cnt_u++;
      if (sel == 4'b0000) cnt_z++;
    end
    chk("units_0000", cnt_u, 4);
`ifdef LEADING_ZERO_BLANK_EN
    chk("blank_0000", cnt_z, 12);
`else
    chk("blank_0000", cnt_z, 0);
`endif

    // reset mid tens slot, during a load
    step(1'b1, 1'b1, 16'h9876);
    guard = 0;
    while (!(m_slot == 1 && m_cnt == 1) && guard < 4 * DIV) begin idle(1); guard++; end
    chk("reach_tens", m_slot, 1);
    step(1'b0, 1'b1, 16'h1111);
    chk("midrst_sel", {28'd0, sel}, 32'h1);
    chk("midrst_dig", {16'd0, millares, centenas, decenas, unidades}, 32'h0);
    cnt_u = 1;
    guard = 0;
    while (sel == 4'b0001 && guard < 10) begin
      idle(1);
      if (sel == 4'b0001) cnt_u++;
      guard++;
    end
    chk("midrst_hold", cnt_u, DIV);
    chk("midrst_next", {28'd0, sel}, 32'h2);

    // load held high: capture evaluated every cycle
    step(1'b1, 1'b1, 16'h0001);
    step(1'b1, 1'b1, 16'h0002);
    step(1'b1, 1'b1, 16'h0A00);
    step(1'b1, 1'b1, 16'h0003);
    step(1'b1, 1'b1, 16'hF999);
    step(1'b1, 1'b1, 16'h9990);
    idle(2);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      rb = 16'($urandom);
      if ($urandom_range(0, 1) == 0)
        rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
              4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 3) == 0) rb[15:8] = 8'h00;
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0), rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
